// File: rtl/hazard_pipe_ctrl_if.sv
// Decode-to-forwarding bundle for hazard_pipe_ctrl: decode-stage fields and branch in,
// shadow-pipe destination fields, stall/flush enables and stall counter out.
interface hazard_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic [4:0]       IFID_Rd;
    logic             IFID_RegWrite;
    logic             IFID_MemRead;
    logic             Branch_Taken;

    logic [4:0]       IDEX_Rd;
    logic             IDEX_RegWrite;
    logic             IDEX_MemRead;
    logic [4:0]       EXMEM_Rd;
    logic             EXMEM_RegWrite;
    logic [4:0]       MEMWB_Rd;
    logic             MEMWB_RegWrite;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic [CNT_W-1:0] stall_cycles;

    // The hazard controller is the master: it produces the forwarding fields.
    modport master (
        input  IFID_Rs, IFID_Rt, IFID_Rd, IFID_RegWrite, IFID_MemRead, Branch_Taken,
        output IDEX_Rd, IDEX_RegWrite, IDEX_MemRead, EXMEM_Rd, EXMEM_RegWrite,
               MEMWB_Rd, MEMWB_RegWrite, PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush,
               stall_cycles
    );

    modport slave (
        output IFID_Rs, IFID_Rt, IFID_Rd, IFID_RegWrite, IFID_MemRead, Branch_Taken,
        input  IDEX_Rd, IDEX_RegWrite, IDEX_MemRead, EXMEM_Rd, EXMEM_RegWrite,
               MEMWB_Rd, MEMWB_RegWrite, PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush,
               stall_cycles
    );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Load-use stall / branch flush controller with shadow Rd/RegWrite pipeline feeding forwarding.
// Optional stall performance counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_pipe_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_pipe_ctrl_if.master hp
);
    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALL - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [4:0] idex_rd_q, exmem_rd_q, memwb_rd_q;
    logic       idex_rw_q, exmem_rw_q, memwb_rw_q;
    logic       idex_mr_q;

    logic       hz;
    logic       pc_write, ifid_write, bubble, flush;

    // A load in ID/EX whose destination feeds the decode instruction; r0 is never a hazard.
    assign hz = idex_mr_q && idex_rw_q && (idex_rd_q != 5'd0) &&
                ((idex_rd_q == hp.IFID_Rs) || (idex_rd_q == hp.IFID_Rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;
        flush      = 1'b0;
        case (state_q)
            RUN: begin
                if (hp.Branch_Taken) begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                end else if (hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    bubble     = 1'b1;
                    if (LOAD_USE_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end
            end
            STALL: begin
                // A taken branch squashes the waiting consumer, so the stall is abandoned.
                if (hp.Branch_Taken) begin
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    bubble     = 1'b1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Shadow pipeline: downstream stages always advance, only ID/EX takes bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_rd_q  <= 5'd0;
            idex_rw_q  <= 1'b0;
            idex_mr_q  <= 1'b0;
            exmem_rd_q <= 5'd0;
            exmem_rw_q <= 1'b0;
            memwb_rd_q <= 5'd0;
            memwb_rw_q <= 1'b0;
        end else begin
            memwb_rd_q <= exmem_rd_q;
            memwb_rw_q <= exmem_rw_q;
            exmem_rd_q <= idex_rd_q;
            exmem_rw_q <= idex_rw_q;
            if (bubble) begin
                idex_rd_q <= 5'd0;
                idex_rw_q <= 1'b0;
                idex_mr_q <= 1'b0;
            end else begin
                idex_rd_q <= hp.IFID_Rd;
                idex_rw_q <= hp.IFID_RegWrite;
                idex_mr_q <= hp.IFID_MemRead;
            end
        end
    end

    assign hp.IDEX_Rd        = idex_rd_q;
    assign hp.IDEX_RegWrite  = idex_rw_q;
    assign hp.IDEX_MemRead   = idex_mr_q;
    assign hp.EXMEM_Rd       = exmem_rd_q;
    assign hp.EXMEM_RegWrite = exmem_rw_q;
    assign hp.MEMWB_Rd       = memwb_rd_q;
    assign hp.MEMWB_RegWrite = memwb_rw_q;
    assign hp.PCWrite        = pc_write;
    assign hp.IFIDWrite      = ifid_write;
    assign hp.IDEX_Bubble    = bubble;
    assign hp.IFID_Flush     = flush;

`ifdef HAZARD_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts frozen-PC cycles only; flushes keep PCWrite high and are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hp.stall_cycles = stall_cnt_q;
`else
    assign hp.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: two instances (1-cycle and 3-cycle load-use stall) driven with
// directed then random decode traffic and compared against a per-instruction reference model.
module tb_hazard_pipe_ctrl;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int NCYC    = 700;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       rw, mr, br;
    } stim_t;

    typedef struct {
        int rd, rw, mr;
    } stage_t;

    typedef struct {
        int idex_rd, idex_rw, idex_mr, exmem_rd, exmem_rw, memwb_rd, memwb_rw;
        int pcw, ifw, bub, fl, cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_pipe_ctrl_if #(.CNT_W(CNT_W)) hif0 ();
    hazard_pipe_ctrl_if #(.CNT_W(CNT_W)) hif1 ();

    hazard_pipe_ctrl #(.LOAD_USE_STALL(1), .CNT_W(CNT_W)) u0 (
        .clk(clk), .rst_n(rst_n), .hp(hif0)
    );
    hazard_pipe_ctrl #(.LOAD_USE_STALL(3), .CNT_W(CNT_W)) u1 (
        .clk(clk), .rst_n(rst_n), .hp(hif1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each instance tracks its three stages and remaining stall cycles.
    stage_t m_idex[2], m_exmem[2], m_memwb[2];
    int     m_rem[2], m_rem_n[2], m_cnt[2];
    int     e_pcw[2], e_ifw[2], e_bub[2], e_fl[2];

    function automatic int stall_len(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic stim_t mk(int rs, int rt, int rd, int rw, int mr, int br);
        stim_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd);
        s.rw = 1'(rw); s.mr = 1'(mr); s.br = 1'(br);
        return s;
    endfunction

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idex[d]  = '{0, 0, 0};
            m_exmem[d] = '{0, 0, 0};
            m_memwb[d] = '{0, 0, 0};
            m_rem[d]   = 0;
            m_cnt[d]   = 0;
        end
    endtask

    task automatic model_outputs(stim_t s);
        for (int d = 0; d < 2; d++) begin
            bit hz;
            hz = (m_idex[d].mr != 0) && (m_idex[d].rw != 0) && (m_idex[d].rd != 0) &&
                 (m_idex[d].rd == int'(s.rs) || m_idex[d].rd == int'(s.rt));
            if (s.br) begin
                e_pcw[d] = 1; e_ifw[d] = 1; e_bub[d] = 1; e_fl[d] = 1;
                m_rem_n[d] = 0;
            end else if (m_rem[d] > 0) begin
                e_pcw[d] = 0; e_ifw[d] = 0; e_bub[d] = 1; e_fl[d] = 0;
                m_rem_n[d] = m_rem[d] - 1;
            end else if (hz) begin
                e_pcw[d] = 0; e_ifw[d] = 0; e_bub[d] = 1; e_fl[d] = 0;
                m_rem_n[d] = stall_len(d) - 1;
            end else begin
                e_pcw[d] = 1; e_ifw[d] = 1; e_bub[d] = 0; e_fl[d] = 0;
                m_rem_n[d] = 0;
            end
        end
    endtask

    task automatic model_edge(stim_t s);
        for (int d = 0; d < 2; d++) begin
            m_memwb[d] = m_exmem[d];
            m_exmem[d] = m_idex[d];
            if (e_bub[d] != 0) m_idex[d] = '{0, 0, 0};
            else               m_idex[d] = '{int'(s.rd), int'(s.rw), int'(s.mr)};
            m_rem[d] = m_rem_n[d];
`ifdef HAZARD_STALL_COUNT_EN
            if (e_pcw[d] == 0 && m_cnt[d] < CNT_MAX) m_cnt[d]++;
`endif
        end
    endtask

    function automatic obs_t get_obs(int d);
        obs_t o;
        if (d == 0) begin
            o = '{hif0.IDEX_Rd, hif0.IDEX_RegWrite, hif0.IDEX_MemRead, hif0.EXMEM_Rd,
                  hif0.EXMEM_RegWrite, hif0.MEMWB_Rd, hif0.MEMWB_RegWrite, hif0.PCWrite,
                  hif0.IFIDWrite, hif0.IDEX_Bubble, hif0.IFID_Flush, hif0.stall_cycles};
        end else begin
            o = '{hif1.IDEX_Rd, hif1.IDEX_RegWrite, hif1.IDEX_MemRead, hif1.EXMEM_Rd,
                  hif1.EXMEM_RegWrite, hif1.MEMWB_Rd, hif1.MEMWB_RegWrite, hif1.PCWrite,
                  hif1.IFIDWrite, hif1.IDEX_Bubble, hif1.IFID_Flush, hif1.stall_cycles};
        end
        return o;
    endfunction

    task automatic check_all(string tag);
        for (int d = 0; d < 2; d++) begin
            obs_t o;
            string p;
            o = get_obs(d);
            p = $sformatf("%s.u%0d", tag, d);
            check_eq({p, ".IDEX_Rd"},        o.idex_rd,  m_idex[d].rd);
            check_eq({p, ".IDEX_RegWrite"},  o.idex_rw,  m_idex[d].rw);
            check_eq({p, ".IDEX_MemRead"},   o.idex_mr,  m_idex[d].mr);
            check_eq({p, ".EXMEM_Rd"},       o.exmem_rd, m_exmem[d].rd);
            check_eq({p, ".EXMEM_RegWrite"}, o.exmem_rw, m_exmem[d].rw);
            check_eq({p, ".MEMWB_Rd"},       o.memwb_rd, m_memwb[d].rd);
            check_eq({p, ".MEMWB_RegWrite"}, o.memwb_rw, m_memwb[d].rw);
            check_eq({p, ".PCWrite"},        o.pcw,      e_pcw[d]);
            check_eq({p, ".IFIDWrite"},      o.ifw,      e_ifw[d]);
            check_eq({p, ".IDEX_Bubble"},    o.bub,      e_bub[d]);
            check_eq({p, ".IFID_Flush"},     o.fl,       e_fl[d]);
            check_eq({p, ".stall_cycles"},   o.cnt,      m_cnt[d]);
        end
    endtask

    task automatic drive(stim_t s);
        hif0.IFID_Rs = s.rs; hif0.IFID_Rt = s.rt; hif0.IFID_Rd = s.rd;
        hif0.IFID_RegWrite = s.rw; hif0.IFID_MemRead = s.mr; hif0.Branch_Taken = s.br;
        hif1.IFID_Rs = s.rs; hif1.IFID_Rt = s.rt; hif1.IFID_Rd = s.rd;
        hif1.IFID_RegWrite = s.rw; hif1.IFID_MemRead = s.mr; hif1.Branch_Taken = s.br;
    endtask

    function automatic stim_t rand_stim();
        return mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 99) < 8));
    endfunction

    initial begin
        stim_t dirq[$];
        stim_t s;
        bit    rst_done;
        rst_done = 1'b0;

        dirq.push_back(mk(0, 0, 5, 1, 0, 0));   // plain writes: Rd flows down the pipe
        dirq.push_back(mk(0, 0, 5, 1, 0, 0));
        dirq.push_back(mk(0, 0, 0, 0, 0, 0));
        dirq.push_back(mk(0, 0, 8, 1, 1, 0));   // load r8
        repeat (4) dirq.push_back(mk(8, 1, 9, 1, 0, 0));  // consumer on Rs, held while stalled
        dirq.push_back(mk(0, 0, 0, 1, 1, 0));   // load r0
        dirq.push_back(mk(0, 0, 4, 1, 0, 0));   // reads r0: no hazard
        dirq.push_back(mk(0, 0, 3, 1, 1, 0));   // load r3
        repeat (3) dirq.push_back(mk(1, 3, 6, 1, 0, 0));  // consumer on Rt
        dirq.push_back(mk(0, 0, 2, 1, 1, 0));   // load r2
        dirq.push_back(mk(2, 0, 7, 1, 0, 1));   // hazard and branch together
        dirq.push_back(mk(0, 0, 1, 1, 1, 0));   // load r1
        dirq.push_back(mk(1, 0, 7, 1, 0, 0));   // hazard starts the stall
        dirq.push_back(mk(1, 0, 7, 1, 0, 1));   // branch in second stall cycle
        dirq.push_back(mk(0, 0, 0, 0, 0, 0));
        repeat (3) begin                        // back-to-back loads and consumers
            dirq.push_back(mk(0, 0, 2, 1, 1, 0));
            repeat (3) dirq.push_back(mk(2, 2, 2, 1, 1, 0));
        end

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        model_reset();
        model_outputs(mk(0, 0, 0, 0, 0, 0));
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            s = (cyc < dirq.size()) ? dirq[cyc] : rand_stim();
            drive(s);
            #2;
            model_outputs(s);
            check_all($sformatf("c%0d", cyc));
            if (!rst_done && cyc > 150 && m_rem[1] > 0 && !s.br) begin
                // Asynchronous reset in the middle of a 3-cycle stall.
                rst_done = 1'b1;
                rst_n = 1'b0;
                #1;
                model_reset();
                model_outputs(s);
                check_all($sformatf("arst%0d", cyc));
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(posedge clk);
                model_edge(s);
                @(negedge clk);
            end
        end

        check_eq("arst_exercised", 32'(rst_done), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_pipe_ctrl.md
Name: hazard_pipe_ctrl

Overview:
- Producer side of the forwarding interface.
- Carries each instruction's destination register and write/load flags through the ID/EX, EX/MEM and MEM/WB stages, and drives EXMEM_Rd, EXMEM_RegWrite, MEMWB_Rd and MEMWB_RegWrite directly into the forwarding unit.
- Detects load-use hazards that forwarding cannot cover: stalls PC and IF/ID and injects bubbles.
- Flushes the front of the pipe on a taken branch.

Parameters:
- LOAD_USE_STALL, 1, number of stall cycles per load-use hazard (legal range 1..3).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IFID_Rs  in  5  source register of the instruction in decode.
- IFID_Rt  in  5  second source register of the instruction in decode.
- IFID_Rd  in  5  destination register of the decode instruction, already selected between Rd and Rt.
- IFID_RegWrite  in  1  decode instruction writes the register file.
- IFID_MemRead  in  1  decode instruction is a load.
- Branch_Taken  in  1  branch resolved taken in EX this cycle.
- IDEX_Rd  out  5  ID/EX destination register.
- IDEX_RegWrite  out  1  ID/EX write flag.
- IDEX_MemRead  out  1  ID/EX load flag.
- EXMEM_Rd  out  5  to forwarding unit.
- EXMEM_RegWrite  out  1  to forwarding unit.
- MEMWB_Rd  out  5  to forwarding unit.
- MEMWB_RegWrite  out  1  to forwarding unit.
- PCWrite  out  1  PC load enable.
- IFIDWrite  out  1  IF/ID register load enable.
- IDEX_Bubble  out  1  datapath zeroes its ID/EX control fields this cycle.
- IFID_Flush  out  1  datapath clears IF/ID this cycle.
- stall_cycles  out  CNT_W  performance counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All Rd fields are 0 and all RegWrite/MemRead flags are 0.
  - FSM goes to RUN and the stall counter goes to 0.
  - Resulting combinational outputs: PCWrite=1, IFIDWrite=1, IDEX_Bubble=0, IFID_Flush=0.
  - Reset asserted during a stall aborts the stall immediately.
- Shadow pipeline, every clock edge:
  - MEMWB fields load from EXMEM.
  - EXMEM fields load from IDEX.
  - IDEX fields load from the IFID inputs, unless IDEX_Bubble=1. In that case IDEX loads Rd=0, RegWrite=0, MemRead=0.
  - The downstream stages never stall.
- Hazard term (combinational): hz = IDEX_MemRead & IDEX_RegWrite & (IDEX_Rd != 0) & (IDEX_Rd == IFID_Rs | IDEX_Rd == IFID_Rt). Register 0 never causes a hazard.
- FSM state RUN:
  - If Branch_Taken: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFIDWrite=1. Stay in RUN.
  - Else if hz: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1.
    - If LOAD_USE_STALL > 1: go to STALL and load cnt = LOAD_USE_STALL-1.
    - Otherwise stay in RUN.
  - Else: all enables = 1, bubble and flush = 0.
- FSM state STALL:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1.
  - cnt decrements by 1 each cycle; when cnt reaches 1, the next state is RUN.
  - hz is ignored in STALL, because the load has left ID/EX.
  - Branch_Taken in STALL: drive the flush outputs exactly as in RUN and return to RUN next cycle. The squashed instruction no longer needs the stall.
- Priority: Branch_Taken over hz.
- Latency:
  - Stall outputs are combinational, in the same cycle the load sits in ID/EX and its consumer sits in IF/ID.
  - Total stall length is exactly LOAD_USE_STALL cycles per hazard.
- Back-to-back case: a consumer of a second load, following a stall, triggers a new hazard normally in RUN.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- With the macro defined:
  - stall_cycles increments by 1 on every clock with PCWrite=0, and saturates at all ones.
  - It is cleared only by reset.
  - Flush cycles are not counted.
- Without the macro: stall_cycles is tied to 0 and no counter flops exist.

Test Plan:
1. Reset, then no hazards: rst_n low for 2 cycles, release; feed Rd=5, RegWrite=1. Required: PCWrite=1 and IFIDWrite=1 throughout; EXMEM_Rd=5 two edges later, MEMWB_Rd=5 three edges later.
2. Load-use with LOAD_USE_STALL=1: load Rd=8 in ID/EX, decode Rs=8. Required: exactly 1 cycle with PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; next cycle EXMEM_Rd=8, IDEX_RegWrite=0.
3. Register 0 and Rt match: load Rd=0 with decode Rs=0 gives no stall. Load Rd=3 with decode Rt=3 gives a stall.
4. LOAD_USE_STALL=3: a single hazard produces exactly 3 consecutive stall cycles and 3 bubbles, then RUN.
5. Branch priority: hz and Branch_Taken in the same cycle give IFID_Flush=1 and PCWrite=1. Branch_Taken in the second STALL cycle ends the stall next cycle.
6. With HAZARD_STALL_COUNT_EN and CNT_W=2: 5 stall cycles give stall_cycles=3 (saturated). Async reset mid-stall gives 0 immediately.
